cbd_sampler_ctrl: RTL and testbench
===================================

Name: cbd_sampler_ctrl

Overview:
Sequences centered-binomial (eta=2) sampling of one polynomial. Accepts a stream of WORD_W-bit pseudorandom words from the PRF/XOF, splits each word into 4-bit nibbles (low nibble first), and converts each nibble to a coefficient reduced into [0, KEM_Q). Writes N_COEFF coefficients to consecutive polynomial-RAM addresses starting at a base address, then pulses done. Sits between the XOF output stream and the poly RAM write port in the keygen/encaps flow.

Parameters:
KEM_Q, 7681, modulus; coefficients are written in [0, KEM_Q)
N_COEFF, 64, coefficients per polynomial; must be a multiple of WORD_W/4
WORD_W, 32, input word width; must be a multiple of 4
ADDR_W, 6, poly RAM address width
COEFF_W, 13, coefficient width; ceil(log2(KEM_Q))

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins one polynomial; ignored unless IDLE
base_addr  in  ADDR_W  first write address; captured on accepted start
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  WORD_W  pseudorandom word
mem_we  out  1  write request
mem_ready  in  1  RAM accepts write this cycle
mem_addr  out  ADDR_W  write address
mem_wdata  out  COEFF_W  coefficient
busy  out  1  high from accepted start until done pulse inclusive
done  out  1  one-cycle pulse after last write accepted

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; state IDLE; counters 0. Reset mid-operation aborts: no further writes, state IDLE, the partial polynomial remains in RAM.
- States: IDLE, LOAD, EMIT, DONE.
- IDLE: on start=1 capture base_addr, clear coeff counter, go to LOAD next cycle; busy rises the cycle after start.
- LOAD: in_ready=1 (combinational from state). On in_valid&&in_ready, latch in_data into a shift register and go to EMIT. in_ready=0 in all other states.
- EMIT: mem_we=1 with registered mem_addr/mem_wdata. The first write appears the cycle after word acceptance. A write completes when mem_we&&mem_ready. On completion, shift by 4, increment address and counter, and present the next coefficient the following cycle. While mem_ready=0, hold mem_we/addr/data stable.
- After the last nibble of a word completes: go to DONE if the counter reaches N_COEFF, otherwise go to LOAD.
- Minimum cost per word, with no stalls: 1 LOAD cycle plus WORD_W/4 EMIT cycles.
- DONE: done=1 for exactly one cycle, mem_we=0, then IDLE. busy falls the cycle after done.
- Coefficient arithmetic for nibble b[3:0]:
  - t = (b0+b1) - (b2+b3), range -2..+2.
  - mem_wdata = t if t>=0, else KEM_Q+t (range 7679..7680).
  - Equivalently, compute (b0+b1)+KEM_Q-(b2+b3) at COEFF_W+1 bits and subtract KEM_Q if the result is >=KEM_Q. Output is always <KEM_Q.
- Address arithmetic wraps modulo 2^ADDR_W (base_addr+N_COEFF-1 may wrap).
- start during busy is ignored; no queuing.
- A word already latched is fully consumed; there is no partial-word discard.

Optional Feature:
CBD_PERF_CNT_EN
- Defined: adds output stall_cnt [15:0]. It counts cycles with (LOAD && !in_valid) or (mem_we && !mem_ready), saturates at 16'hFFFF, clears on accepted start, and resets to 0. Its value is held after done.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package cbd_pkg holds:
  - KEM_Q, ETA=2, COEFF_W
  - state enum type cbd_state_t {IDLE, LOAD, EMIT, DONE}
  - function nibbles_per_word(WORD_W)
- Sub-module cbd_coeff is natural: purely combinational 4-bit nibble -> reduced COEFF_W coefficient. Instantiate it once on the shift-register low nibble.

Test Plan:
- Reset: hold rst 3 cycles with start=1 -> all outputs 0, no writes, busy=0.
- Coefficient mapping: start with base_addr=0, one word 32'h4C31_F0C3, mem_ready=1 -> addr 0..7 receive 2,7679,0,0,1,2,7679,7680.
- Full polynomial: N_COEFF=64, 8 words of 32'hFFFF_FFFF, in_valid always high -> 64 writes of 0; done pulses once, 72 cycles after the first word is accepted; busy then falls.
- Backpressure: mem_ready toggles 0/1 each cycle; in_valid is withheld 5 cycles before word 3 -> no lost or duplicated writes, addr/data stable while stalled; with CBD_PERF_CNT_EN, stall_cnt equals the counted stall cycles.
- Wrap and busy start: base_addr=6'h3C, words 32'h3333_3333 -> writes at 3C..3F, then 00..3B, all 2; a start pulse mid-run is ignored.
- Reset mid-EMIT: assert rst after the 3rd write of word 2 -> mem_we=0 next cycle; a new start afterwards produces a correct full polynomial.

Source files
------------

// File: rtl/cbd_pkg.sv
// cbd_pkg: shared constants, FSM state type and helpers for the CBD (eta=2)
// polynomial sampler.
package cbd_pkg;

  localparam int KEM_Q   = 7681;
  localparam int ETA     = 2;
  localparam int COEFF_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } cbd_state_t;

  // Each eta=2 sample consumes one 4-bit nibble.
  function automatic int nibbles_per_word(input int word_w);
    return word_w / 4;
  endfunction

endpackage

// File: rtl/cbd_coeff.sv
// cbd_coeff: combinational map of one 4-bit nibble to a centered-binomial
// coefficient reduced into [0, KEM_Q).
module cbd_coeff
  import cbd_pkg::*;
(
  input  logic [3:0]         i_nib,
  output logic [COEFF_W-1:0] o_coeff
);

  localparam logic [COEFF_W:0] KQ = (COEFF_W + 1)'(KEM_Q);

  logic [COEFF_W:0] w_pos;
  logic [COEFF_W:0] w_neg;
  logic [COEFF_W:0] w_sum;
  logic [COEFF_W:0] w_red;

  // (b0+b1) + Q - (b2+b3) never underflows; one conditional subtract reduces it.
  assign w_pos = {{COEFF_W{1'b0}}, i_nib[0]} + {{COEFF_W{1'b0}}, i_nib[1]};
  assign w_neg = {{COEFF_W{1'b0}}, i_nib[2]} + {{COEFF_W{1'b0}}, i_nib[3]};
  assign w_sum = w_pos + KQ - w_neg;
  assign w_red = w_sum - KQ;

  // Select the reduced or unreduced sum so the output stays below KEM_Q.
  always_comb begin
    o_coeff = w_sum[COEFF_W-1:0];
    if (w_sum >= KQ) begin
      o_coeff = w_red[COEFF_W-1:0];
    end else begin
      o_coeff = w_sum[COEFF_W-1:0];
    end
  end

endmodule

// File: rtl/cbd_sampler_ctrl.sv
// cbd_sampler_ctrl: consumes pseudorandom words, turns each nibble (low first)
// into a CBD eta=2 coefficient and writes N_COEFF of them to consecutive RAM
// addresses from a captured base, then pulses done.
// Optional build macro CBD_PERF_CNT_EN adds the stall_cnt output.
module cbd_sampler_ctrl
  import cbd_pkg::*;
#(
  parameter int N_COEFF = 64,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COEFF_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done
`ifdef CBD_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int NPW   = nibbles_per_word(WORD_W);
  localparam int NIB_W = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int CNT_W = $clog2(N_COEFF + 1);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NPW - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_COEFF - 1);

  cbd_state_t         r_state;
  logic [WORD_W-5:0]  r_shift;   // nibbles not yet presented, next one in [3:0]
  logic [NIB_W-1:0]   r_nib;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [COEFF_W-1:0] r_wdata;
  logic               r_we;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_wr_done;
  logic [3:0]         w_nib;
  logic [COEFF_W-1:0] w_coeff;

  assign in_ready  = (r_state == LOAD);
  assign w_accept  = in_ready && in_valid;
  assign w_wr_done = r_we && mem_ready;

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;

  // Nibble feeding the coefficient mapper: the incoming word's low nibble while
  // loading, otherwise the next pending nibble of the shift register.
  always_comb begin
    w_nib = r_shift[3:0];
    if (r_state == LOAD) begin
      w_nib = in_data[3:0];
    end else begin
      w_nib = r_shift[3:0];
    end
  end

  cbd_coeff u_coeff (
    .i_nib   (w_nib),
    .o_coeff (w_coeff)
  );

  // Main sequencer with registered write-port, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_nib   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr  <= base_addr;
            r_cnt   <= '0;
            r_nib   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_shift <= in_data[WORD_W-1:4];
            r_wdata <= w_coeff;
            r_we    <= 1'b1;
            r_nib   <= '0;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_wr_done) begin
            r_shift <= {4'b0000, r_shift[WORD_W-5:4]};
            r_addr  <= r_addr + ADDR_W'(1);
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_nib == LAST_NIB) begin
              r_we  <= 1'b0;
              r_nib <= '0;
              if (r_cnt == LAST_CNT) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_state <= LOAD;
              end
            end else begin
              r_nib   <= r_nib + NIB_W'(1);
              r_wdata <= w_coeff;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef CBD_PERF_CNT_EN
  logic [15:0] r_stall;
  assign stall_cnt = r_stall;

  // Saturating count of cycles lost to a missing input word or a busy RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 16'h0000;
    end else if ((r_state == IDLE) && start) begin
      r_stall <= 16'h0000;
    end else if (((r_state == LOAD) && !in_valid) || (r_we && !mem_ready)) begin
      if (r_stall != 16'hFFFF) begin
        r_stall <= r_stall + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cbd_sampler_ctrl.sv
// tb_cbd_sampler_ctrl: randomized, self-checking bench for cbd_sampler_ctrl.
// Expected writes come from a nibble-level model of the CBD mapping.
`timescale 1ns/1ps
module tb_cbd_sampler_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  base_addr = 6'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [5:0]  mem_addr;
  logic [12:0] mem_wdata;
  logic        busy;
  logic        done;
`ifdef CBD_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] words[$];
  logic [5:0]  wq_addr[$];
  logic [12:0] wq_data[$];
  int          stab_err = 0;
  int          done_pulses = 0;

  cbd_sampler_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
`ifdef CBD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: records accepted writes, done pulses and write-port changes during stalls.
  logic        p_stall = 1'b0;
  logic        p_rst = 1'b1;
  logic        p_we = 1'b0;
  logic [5:0]  p_addr = 6'd0;
  logic [12:0] p_data = 13'd0;
  always @(posedge clk) begin
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
    if (p_stall && !p_rst &&
        (mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_data))
      stab_err++;
    if (done === 1'b1) done_pulses++;
    p_stall = (mem_we === 1'b1 && mem_ready === 1'b0);
    p_rst   = rst;
    p_we    = mem_we;
    p_addr  = mem_addr;
    p_data  = mem_wdata;
  end

  // Centered binomial eta=2 value of a nibble, lifted into [0, 7681).
  function automatic int ref_coeff(input logic [3:0] b);
    int t;
    t = int'(b[0]) + int'(b[1]) - int'(b[2]) - int'(b[3]);
    return (t < 0) ? 7681 + t : t;
  endfunction

  // Expected data of the i-th write of a polynomial built from 'words'.
  function automatic logic [12:0] exp_data(input int i);
    logic [31:0] w;
    logic [3:0]  nib;
    w   = words[i / 8];
    nib = w[4 * (i % 8) +: 4];
    return 13'(ref_coeff(nib));
  endfunction

  // Starts one polynomial and drives words / RAM backpressure until done,
  // a write-count stop point, or the cycle budget. Call at #1 after an edge.
  task automatic run_poly(input logic [5:0] base, input int nw, input int rmode,
                          input int wh_word, input int mid_start, input int stop_at,
                          input int max_cyc, output int done_cyc, output int acc_cyc,
                          output int stalls);
    int idx, wh, cyc, w0;
    idx = 0; wh = 0; cyc = 0; done_cyc = -1; acc_cyc = -1; stalls = 0;
    w0 = wq_addr.size();
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 6'($urandom);
    while (cyc < max_cyc) begin
      if (stop_at > 0 && (wq_addr.size() - w0) >= stop_at) break;
      if (rmode == 0) mem_ready = 1'b1;
      else if (rmode == 1) mem_ready = cyc[0];
      else mem_ready = 1'($urandom_range(1, 0));
      if (idx < nw && in_ready && idx == wh_word && wh < 5) begin
        in_valid = 1'b0;
        wh++;
      end else if (idx < nw) begin
        in_valid = 1'b1;
        in_data  = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        idx++;
      end
      if ((in_ready && !in_valid) || (mem_we && !mem_ready)) stalls++;
      start = (cyc == mid_start);
      base_addr = 6'($urandom);
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_addr = 6'h15; in_valid = 1'b1; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/we/busy/done %b want 0000", {in_ready, mem_we, busy, done});
    end
    checks++;
    if (mem_addr !== 6'd0 || mem_wdata !== 13'd0) begin
      errors++;
      $display("FAIL reset_bus got addr %h data %0d want 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (wq_addr.size() != 0) begin
      errors++;
      $display("FAIL reset_writes got %0d writes want 0", wq_addr.size());
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_coeff_map();
    int dc, ac, st, w0, n;
    int want[8] = '{2, 7679, 0, 0, 1, 2, 7679, 7680};
    words.delete();
    words.push_back(32'h4C31_F0C3);
    w0 = wq_addr.size();
    run_poly(6'd0, 1, 0, -1, -1, 8, 40, dc, ac, st);
    n = wq_addr.size() - w0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL map_count got %0d writes want 8", n);
    end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++;
      if (wq_addr[w0 + i] !== 6'(i) || int'(wq_data[w0 + i]) != want[i] ||
          wq_data[w0 + i] !== exp_data(i)) begin
        errors++;
        $display("FAIL map_write[%0d] got addr %h data %0d want addr %h data %0d",
                 i, wq_addr[w0 + i], wq_data[w0 + i], 6'(i), want[i]);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL map_wait got rdy %b busy %b want 1 1", in_ready, busy);
    end
    mem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_poly();
    int dc, ac, st, w0, n, d0;
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(32'hFFFF_FFFF);
    w0 = wq_addr.size();
    d0 = done_pulses;
    run_poly(6'd0, 8, 0, -1, -1, 0, 200, dc, ac, st);
    checks++;
    if (dc < 0 || dc - ac != 72) begin
      errors++;
      $display("FAIL full_latency got %0d cycles want 72 (done_cyc %0d)", dc - ac, dc);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL full_busy_at_done got %b want 1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_pulses - d0 != 1) begin
      errors++;
      $display("FAIL full_after got busy %b done %b pulses %0d want 0 0 1",
               busy, done, done_pulses - d0);
    end
    n = wq_addr.size() - w0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL full_count got %0d writes want 64", n);
    end
    for (int i = 0; i < 64 && i < n; i++) begin
      checks++;
      if (wq_addr[w0 + i] !== 6'(i) || wq_data[w0 + i] !== 13'd0) begin
        errors++;
        $display("FAIL full_write[%0d] got addr %h data %0d want addr %h data 0",
                 i, wq_addr[w0 + i], wq_data[w0 + i], 6'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    int dc, ac, st, w0, n, s0;
    logic [5:0] base;
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    base = 6'($urandom);
    w0 = wq_addr.size();
    s0 = stab_err;
    run_poly(base, 8, 1, 2, -1, 0, 400, dc, ac, st);
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL bp_done got no done within budget want done");
    end
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes during stall want 0", stab_err - s0);
    end
`ifdef CBD_PERF_CNT_EN
    checks++;
    if (int'(stall_cnt) != st) begin
      errors++;
      $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, st);
    end
`endif
    @(posedge clk); #1;
    n = wq_addr.size() - w0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL bp_count got %0d writes want 64", n);
    end
    for (int i = 0; i < 64 && i < n; i++) begin
      checks++;
      if (wq_addr[w0 + i] !== 6'(base + i) || wq_data[w0 + i] !== exp_data(i)) begin
        errors++;
        $display("FAIL bp_write[%0d] got addr %h data %0d want addr %h data %0d",
                 i, wq_addr[w0 + i], wq_data[w0 + i], 6'(base + i), exp_data(i));
      end
    end
  endtask

  task automatic test_wrap_busy_start();
    int dc, ac, st, w0, n;
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(32'h3333_3333);
    w0 = wq_addr.size();
    run_poly(6'h3C, 8, 2, -1, 20, 0, 400, dc, ac, st);
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL wrap_done got no done within budget want done");
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle got busy %b rdy %b want 0 0", busy, in_ready);
    end
    n = wq_addr.size() - w0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL wrap_count got %0d writes want 64", n);
    end
    for (int i = 0; i < 64 && i < n; i++) begin
      checks++;
      if (wq_addr[w0 + i] !== 6'(6'h3C + i) || wq_data[w0 + i] !== 13'd2) begin
        errors++;
        $display("FAIL wrap_write[%0d] got addr %h data %0d want addr %h data 2",
                 i, wq_addr[w0 + i], wq_data[w0 + i], 6'(6'h3C + i));
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int dc, ac, st, w0, n;
    logic [5:0] base;
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    w0 = wq_addr.size();
    run_poly(6'd9, 8, 0, -1, -1, 11, 100, dc, ac, st);
    mem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got we %b busy %b rdy %b want 0 0 0", mem_we, busy, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wq_addr.size() - w0 != 11) begin
      errors++;
      $display("FAIL rst_mid_writes got %0d writes want 11", wq_addr.size() - w0);
    end
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    base = 6'($urandom);
    w0 = wq_addr.size();
    run_poly(base, 8, 2, -1, -1, 0, 400, dc, ac, st);
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL rst_rerun_done got no done within budget want done");
    end
    @(posedge clk); #1;
    n = wq_addr.size() - w0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL rst_rerun_count got %0d writes want 64", n);
    end
    for (int i = 0; i < 64 && i < n; i++) begin
      checks++;
      if (wq_addr[w0 + i] !== 6'(base + i) || wq_data[w0 + i] !== exp_data(i)) begin
        errors++;
        $display("FAIL rst_rerun_write[%0d] got addr %h data %0d want addr %h data %0d",
                 i, wq_addr[w0 + i], wq_data[w0 + i], 6'(base + i), exp_data(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_coeff_map();
    test_full_poly();
    test_backpressure();
    test_wrap_busy_start();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
